usb_ep_trans_ctrl: RTL and testbench
====================================

# usb_ep_trans_ctrl

Per-endpoint transaction sequencer between the packet receiver/transmitter and the endpoint's IN and OUT BRAM FIFOs. It decodes token starts and drives the FIFO fill/pop transaction strobes. It also tracks the DATA0/DATA1 toggles, chooses the handshake (ACK/NAK/STALL) or data PID to send, and commits or rewinds FIFO transactions depending on the transaction outcome.

## Interface
Parameters:
- MAX_PACKET_SIZE, 64: max data payload bytes per packet (1..512)
- ACK_TIMEOUT, 200: cycles waited for a host ACK after an IN data packet (>=1)

Ports:
- clk12_i  in  1  12 MHz clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- gotTransStartPacket_i  in  1  one-cycle pulse: token packet for this endpoint received
- transStartTokenID_i  in  2  token PID[3:2]: OUT=00, SOF=01, IN=10, SETUP=11
- rxDataValid_i  in  1  data-packet payload byte valid
- rxData_i  in  8  payload byte
- rxPacketDone_i  in  1  one-cycle pulse: data packet ended
- rxPacketOk_i  in  1  CRC/PID ok; sampled with rxPacketDone_i
- rxDataToggle_i  in  1  received data PID toggle (DATA1=1); sampled with rxPacketDone_i
- hostAck_i  in  1  one-cycle pulse: host ACK handshake received
- respAck_i  in  1  transmitter accepted the pending response
- txPopData_i  in  1  transmitter consumes txData_o this cycle
- txDone_i  in  1  one-cycle pulse: IN data packet fully sent
- halt_i  in  1  endpoint halted (only with USB_EP_HALT_EN)
- EP_OUT_dataValid_o / EP_OUT_data_o  out  1/8  OUT FIFO write
- EP_OUT_fillTransDone_o / EP_OUT_fillTransSuccess_o  out  1/1  OUT FIFO commit strobe/outcome
- EP_OUT_full_i  in  1  OUT FIFO full
- EP_IN_popData_o  out  1  IN FIFO pop
- EP_IN_popTransDone_o / EP_IN_popTransSuccess_o  out  1/1  IN FIFO commit strobe/outcome (0 = rewind)
- EP_IN_dataAvailable_i / EP_IN_data_i  in  1/8  IN FIFO status/head byte
- txDataAvailable_o / txData_o  out  1/8  byte offered to transmitter
- respValid_o  out  1  response pending
- respHandshakePID_o  out  1  1 = handshake, 0 = data PID
- respPacketID_o  out  2  PID[3:2]: ACK=00, NAK=10, STALL=11; DATA0=00, DATA1=10
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, OUT_RX, OUT_RESP, IN_RESP, IN_TX, IN_WAIT_ACK.
- Registers: outToggle and inToggle (expected/next toggle), byteCnt (10 bit), overflow, discard, timer.
- IDLE:
  - OUT token -> OUT_RX with expected toggle = outToggle.
  - SETUP token -> OUT_RX with expected toggle = 0.
  - IN token -> IN_RESP.
  - SOF -> ignored.
- OUT_RX:
  - EP_OUT_dataValid_o = rxDataValid_i & !discard & !overflow; EP_OUT_data_o = rxData_i (combinational).
  - A byte arriving while EP_OUT_full_i or byteCnt == MAX_PACKET_SIZE sets overflow.
- On rxPacketDone_i:
  - !rxPacketOk_i -> fillTransDone with success=0, no response, go to IDLE.
  - Otherwise match = (rxDataToggle_i == expected); success = match & !overflow & !halted.
  - Response: STALL if halted, else NAK if overflow, else ACK. A toggle mismatch is ACKed but discarded.
  - On success, outToggle flips. After SETUP success, outToggle = inToggle = 1.
  - Next state OUT_RESP.
- IN_RESP:
  - halted -> STALL; !EP_IN_dataAvailable_i -> NAK.
  - Otherwise respond with data PID from inToggle, then go to IN_TX once respAck_i.
- IN_TX:
  - txDataAvailable_o = EP_IN_dataAvailable_i & byteCnt < MAX_PACKET_SIZE.
  - EP_IN_popData_o = txPopData_i & txDataAvailable_o; txData_o = EP_IN_data_i.
  - txDone_i -> IN_WAIT_ACK, timer = 0.
- IN_WAIT_ACK:
  - hostAck_i -> popTransDone with success=1, inToggle flips.
  - timer == ACK_TIMEOUT-1, or a new gotTransStartPacket_i -> popTransDone with success=0. That token is dropped; the host retries.
  - Both cases -> IDLE.
- Tokens received in any state other than IDLE and IN_WAIT_ACK are ignored.

## Timing
- Reset: all outputs 0, state IDLE, toggles 0, counters 0. No FIFO Done strobes are issued on reset; the FIFOs are reset alongside.
- fill/popTransDone_o: exactly one cycle wide, one cycle after the triggering event (rxPacketDone_i, hostAck_i or timeout); Success is valid in the same cycle.
- respValid_o: rises the cycle after the decision. respPacketID_o and respHandshakePID_o are stable while respValid_o is high. respValid_o drops the cycle after respAck_i, then the state advances (OUT_RESP -> IDLE, IN_RESP -> IN_TX or IDLE).
- Zero-length OUT packet: legal, commits 0 bytes. IN with MAX_PACKET_SIZE bytes in FIFO: offer stops after exactly MAX_PACKET_SIZE pops.

## Configuration
- USB_EP_HALT_EN defined:
  - halt_i port exists.
  - halt_i high forces STALL for OUT/IN/SETUP and blocks all FIFO writes and pops.
- USB_EP_HALT_EN undefined:
  - no halt_i port; halted is constant 0.
  - STALL is never emitted.

## Structure
- usb_ep_pkg holds:
  - token encodings (OUT/SOF/IN/SETUP);
  - handshake encodings (ACK/NAK/STALL) and data PID encodings (DATA0/DATA1);
  - the state enum typedef.
- One sub-module, usb_ep_ack_timer: loadable counter with an expiry pulse, used in IN_WAIT_ACK.

## Test plan
- OUT, 8 bytes, DATA0, rxPacketOk=1, outToggle=0 -> 8 FIFO writes; fillTransDone+Success=1; ACK (00); outToggle=1.
- OUT, DATA0 while outToggle=1 -> fillTransSuccess=0; ACK sent; outToggle stays 1.
- OUT, 70 bytes with MAX_PACKET_SIZE=64 -> 64 writes; overflow; success=0; NAK (10).
- IN, 5 bytes queued, inToggle=0 -> DATA0 (00, handshake=0); 5 pops; hostAck -> popTransSuccess=1; inToggle=1.
- IN, no host ACK -> popTransDone with success=0 exactly ACK_TIMEOUT cycles after txDone; repeat IN yields DATA0 with identical bytes.
- With USB_EP_HALT_EN, halt_i=1, IN then OUT -> STALL (11) for both; no pops, no writes.

Source files
------------

// File: rtl/usb_ep_pkg.sv
// Shared encodings for the USB endpoint transaction sequencer:
// token PIDs, handshake/data PIDs and the sequencer state type.
package usb_ep_pkg;

   // Token PID[3:2] as delivered by the packet receiver
   localparam logic [1:0] TOK_OUT   = 2'b00;
   localparam logic [1:0] TOK_SOF   = 2'b01;
   localparam logic [1:0] TOK_IN    = 2'b10;
   localparam logic [1:0] TOK_SETUP = 2'b11;

   // Handshake PID[3:2]
   localparam logic [1:0] PID_ACK   = 2'b00;
   localparam logic [1:0] PID_NAK   = 2'b10;
   localparam logic [1:0] PID_STALL = 2'b11;

   // Data PID[3:2]
   localparam logic [1:0] PID_DATA0 = 2'b00;
   localparam logic [1:0] PID_DATA1 = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OUT_RX,
      ST_OUT_RESP,
      ST_IN_RESP,
      ST_IN_TX,
      ST_IN_WAIT_ACK
   } state_e;

   // Data PID that carries the given toggle bit
   function automatic logic [1:0] data_pid(input logic toggle);
      return toggle ? PID_DATA1 : PID_DATA0;
   endfunction

endpackage

// File: rtl/usb_ep_ack_timer.sv
// Host-ACK wait timer: cleared by i_load, counts while i_en is high and
// flags o_expired on the last cycle of the TIMEOUT-cycle window.
module usb_ep_ack_timer #(
   parameter int TIMEOUT = 200
) (
   input  logic clk12_i,
   input  logic rst_i,
   input  logic i_load,
   input  logic i_en,
   output logic o_expired
);

   localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [W-1:0] r_cnt;

   // Counter: cleared on load, advances while enabled, holds at expiry
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk12_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= '0;
      end else if (i_en && !o_expired) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_expired = i_en && (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/usb_ep_trans_ctrl.sv
// Per-endpoint transaction sequencer between the USB packet rx/tx and the
// endpoint's IN/OUT FIFOs: decodes tokens, streams payload bytes, tracks
// DATA0/DATA1 toggles, picks the response PID and commits or rewinds FIFO
// transactions. Optional halt support is enabled by defining USB_EP_HALT_EN.
module usb_ep_trans_ctrl
   import usb_ep_pkg::*;
#(
   parameter int MAX_PACKET_SIZE = 64,
   parameter int ACK_TIMEOUT     = 200
) (
   input  logic       clk12_i,
   input  logic       rst_i,
   input  logic       gotTransStartPacket_i,
   input  logic [1:0] transStartTokenID_i,
   input  logic       rxDataValid_i,
   input  logic [7:0] rxData_i,
   input  logic       rxPacketDone_i,
   input  logic       rxPacketOk_i,
   input  logic       rxDataToggle_i,
   input  logic       hostAck_i,
   input  logic       respAck_i,
   input  logic       txPopData_i,
   input  logic       txDone_i,
`ifdef USB_EP_HALT_EN
   input  logic       halt_i,
`endif
   output logic       EP_OUT_dataValid_o,
   output logic [7:0] EP_OUT_data_o,
   output logic       EP_OUT_fillTransDone_o,
   output logic       EP_OUT_fillTransSuccess_o,
   input  logic       EP_OUT_full_i,
   output logic       EP_IN_popData_o,
   output logic       EP_IN_popTransDone_o,
   output logic       EP_IN_popTransSuccess_o,
   input  logic       EP_IN_dataAvailable_i,
   input  logic [7:0] EP_IN_data_i,
   output logic       txDataAvailable_o,
   output logic [7:0] txData_o,
   output logic       respValid_o,
   output logic       respHandshakePID_o,
   output logic [1:0] respPacketID_o,
   output logic       busy_o
);

   localparam logic [9:0] MAX_CNT = 10'(MAX_PACKET_SIZE);

   // Registered state
   state_e     r_state;
   logic       r_out_toggle, r_in_toggle, r_exp_toggle, r_is_setup;
   logic [9:0] r_byte_cnt;
   logic       r_overflow, r_discard;
   logic       r_resp_valid, r_resp_hs;
   logic [1:0] r_resp_pid;
   logic       r_fill_done, r_fill_success, r_pop_done, r_pop_success;

   // Next-state values
   state_e     w_state_nxt;
   logic       w_out_toggle_nxt, w_in_toggle_nxt, w_exp_toggle_nxt, w_is_setup_nxt;
   logic [9:0] w_byte_cnt_nxt;
   logic       w_overflow_nxt, w_discard_nxt;
   logic       w_resp_valid_nxt, w_resp_hs_nxt;
   logic [1:0] w_resp_pid_nxt;
   logic       w_fill_done_nxt, w_fill_success_nxt, w_pop_done_nxt, w_pop_success_nxt;

   logic w_halted, w_match, w_success, w_tmr_load, w_tmr_en, w_tmr_expired;

`ifdef USB_EP_HALT_EN
   assign w_halted = halt_i;
`else
   assign w_halted = 1'b0;
`endif

   usb_ep_ack_timer #(
      .TIMEOUT (ACK_TIMEOUT)
   ) u_ack_timer (
      .clk12_i   (clk12_i),
      .rst_i     (rst_i),
      .i_load    (w_tmr_load),
      .i_en      (w_tmr_en),
      .o_expired (w_tmr_expired)
   );

   // State and bookkeeping registers
   always_ff @(posedge clk12_i) begin
      if (rst_i) begin
         r_state        <= ST_IDLE;
         r_out_toggle   <= 1'b0;
         r_in_toggle    <= 1'b0;
         r_exp_toggle   <= 1'b0;
         r_is_setup     <= 1'b0;
         r_byte_cnt     <= '0;
         r_overflow     <= 1'b0;
         r_discard      <= 1'b0;
         r_resp_valid   <= 1'b0;
         r_resp_hs      <= 1'b0;
         r_resp_pid     <= '0;
         r_fill_done    <= 1'b0;
         r_fill_success <= 1'b0;
         r_pop_done     <= 1'b0;
         r_pop_success  <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_out_toggle   <= w_out_toggle_nxt;
         r_in_toggle    <= w_in_toggle_nxt;
         r_exp_toggle   <= w_exp_toggle_nxt;
         r_is_setup     <= w_is_setup_nxt;
         r_byte_cnt     <= w_byte_cnt_nxt;
         r_overflow     <= w_overflow_nxt;
         r_discard      <= w_discard_nxt;
         r_resp_valid   <= w_resp_valid_nxt;
         r_resp_hs      <= w_resp_hs_nxt;
         r_resp_pid     <= w_resp_pid_nxt;
         r_fill_done    <= w_fill_done_nxt;
         r_fill_success <= w_fill_success_nxt;
         r_pop_done     <= w_pop_done_nxt;
         r_pop_success  <= w_pop_success_nxt;
      end
   end

   // Next-state logic and combinational FIFO/transmitter strobes
   // NOTE: every signal gets a default before the case statement so no
   // path leaves a value unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt        = r_state;
      w_out_toggle_nxt   = r_out_toggle;
      w_in_toggle_nxt    = r_in_toggle;
      w_exp_toggle_nxt   = r_exp_toggle;
      w_is_setup_nxt     = r_is_setup;
      w_byte_cnt_nxt     = r_byte_cnt;
      w_overflow_nxt     = r_overflow;
      w_discard_nxt      = r_discard;
      w_resp_valid_nxt   = r_resp_valid;
      w_resp_hs_nxt      = r_resp_hs;
      w_resp_pid_nxt     = r_resp_pid;
      w_fill_done_nxt    = 1'b0;
      w_fill_success_nxt = 1'b0;
      w_pop_done_nxt     = 1'b0;
      w_pop_success_nxt  = 1'b0;
      w_match            = 1'b0;
      w_success          = 1'b0;
      w_tmr_load         = 1'b0;
      w_tmr_en           = 1'b0;
      EP_OUT_dataValid_o = 1'b0;
      EP_OUT_data_o      = '0;
      EP_IN_popData_o    = 1'b0;
      txDataAvailable_o  = 1'b0;
      txData_o           = '0;

      unique case (r_state)
         ST_IDLE: begin
            if (gotTransStartPacket_i) begin
               w_byte_cnt_nxt = '0;
               w_overflow_nxt = 1'b0;
               w_discard_nxt  = w_halted;
               case (transStartTokenID_i)
                  TOK_OUT: begin
                     w_state_nxt      = ST_OUT_RX;
                     w_exp_toggle_nxt = r_out_toggle;
                     w_is_setup_nxt   = 1'b0;
                  end
                  TOK_SETUP: begin
                     w_state_nxt      = ST_OUT_RX;
                     w_exp_toggle_nxt = 1'b0;
                     w_is_setup_nxt   = 1'b1;
                  end
                  TOK_IN:  w_state_nxt = ST_IN_RESP;
                  default: ;  // SOF carries no endpoint transaction
               endcase
            end
         end

         ST_OUT_RX: begin
            EP_OUT_data_o      = rxData_i;
            EP_OUT_dataValid_o = rxDataValid_i && !r_discard && !w_halted && !r_overflow &&
                                 !EP_OUT_full_i && (r_byte_cnt != MAX_CNT);
            if (rxDataValid_i && (EP_OUT_full_i || (r_byte_cnt == MAX_CNT))) begin
               w_overflow_nxt = 1'b1;
            end
            if (EP_OUT_dataValid_o) begin
               w_byte_cnt_nxt = r_byte_cnt + 10'd1;
            end
            if (rxPacketDone_i) begin
               w_fill_done_nxt = 1'b1;
               if (!rxPacketOk_i) begin
                  // Corrupt packet: rewind silently and let the host retry
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_match            = (rxDataToggle_i == r_exp_toggle);
                  w_success          = w_match && !w_overflow_nxt && !w_halted && !r_discard;
                  w_fill_success_nxt = w_success;
                  w_resp_valid_nxt   = 1'b1;
                  w_resp_hs_nxt      = 1'b1;
                  // A toggle mismatch is a retransmission: ACK it but drop the data
                  w_resp_pid_nxt     = w_halted       ? PID_STALL :
                                       w_overflow_nxt ? PID_NAK   : PID_ACK;
                  if (w_success) begin
                     if (r_is_setup) begin
                        w_out_toggle_nxt = 1'b1;
                        w_in_toggle_nxt  = 1'b1;
                     end else begin
                        w_out_toggle_nxt = !r_out_toggle;
                     end
                  end
                  w_state_nxt = ST_OUT_RESP;
               end
            end
         end

         ST_OUT_RESP: begin
            if (r_resp_valid && respAck_i) begin
               w_resp_valid_nxt = 1'b0;
               w_state_nxt      = ST_IDLE;
            end
         end

         ST_IN_RESP: begin
            if (!r_resp_valid) begin
               w_resp_valid_nxt = 1'b1;
               if (w_halted) begin
                  w_resp_hs_nxt  = 1'b1;
                  w_resp_pid_nxt = PID_STALL;
               end else if (!EP_IN_dataAvailable_i) begin
                  w_resp_hs_nxt  = 1'b1;
                  w_resp_pid_nxt = PID_NAK;
               end else begin
                  w_resp_hs_nxt  = 1'b0;
                  w_resp_pid_nxt = data_pid(r_in_toggle);
               end
            end else if (respAck_i) begin
               w_resp_valid_nxt = 1'b0;
               w_state_nxt      = r_resp_hs ? ST_IDLE : ST_IN_TX;
            end
         end

         ST_IN_TX: begin
            txDataAvailable_o = EP_IN_dataAvailable_i && (r_byte_cnt < MAX_CNT) && !w_halted;
            EP_IN_popData_o   = txPopData_i && txDataAvailable_o;
            txData_o          = EP_IN_data_i;
            if (EP_IN_popData_o) begin
               w_byte_cnt_nxt = r_byte_cnt + 10'd1;
            end
            if (txDone_i) begin
               w_tmr_load  = 1'b1;
               w_state_nxt = ST_IN_WAIT_ACK;
            end
         end

         ST_IN_WAIT_ACK: begin
            w_tmr_en = 1'b1;
            if (hostAck_i) begin
               w_pop_done_nxt    = 1'b1;
               w_pop_success_nxt = 1'b1;
               w_in_toggle_nxt   = !r_in_toggle;
               w_state_nxt       = ST_IDLE;
            end else if (w_tmr_expired || gotTransStartPacket_i) begin
               // Lost ACK or host moved on: rewind so the retry resends the same bytes
               w_pop_done_nxt = 1'b1;
               w_state_nxt    = ST_IDLE;
            end
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign EP_OUT_fillTransDone_o    = r_fill_done;
   assign EP_OUT_fillTransSuccess_o = r_fill_success;
   assign EP_IN_popTransDone_o      = r_pop_done;
   assign EP_IN_popTransSuccess_o   = r_pop_success;
   assign respValid_o               = r_resp_valid;
   assign respHandshakePID_o        = r_resp_hs;
   assign respPacketID_o            = r_resp_pid;
   assign busy_o                    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_usb_ep_trans_ctrl.sv
// Scoreboard bench for usb_ep_trans_ctrl: stimulus tasks queue the expected
// FIFO writes, commits, responses and pops; a negedge monitor checks them in order.
module tb_usb_ep_trans_ctrl;
   import usb_ep_pkg::*;

   localparam int MAXP = 64;
   localparam int ATO  = 20;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       got_tok = 1'b0;
   logic [1:0] tok_id = '0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_done = 1'b0, rx_ok = 1'b0, rx_tgl = 1'b0;
   logic       host_ack = 1'b0, resp_ack = 1'b0, tx_pop = 1'b0, tx_done = 1'b0;
   logic       halt = 1'b0;
   logic       out_full = 1'b0;

   logic       out_valid, out_fill_done, out_fill_succ;
   logic [7:0] out_data;
   logic       in_pop, in_pop_done, in_pop_succ;
   logic       in_avail;
   logic [7:0] in_data;
   logic       tx_avail;
   logic [7:0] tx_data;
   logic       resp_valid, resp_hs, busy;
   logic [1:0] resp_pid;

   always #5 clk = ~clk;

   usb_ep_trans_ctrl #(.MAX_PACKET_SIZE(MAXP), .ACK_TIMEOUT(ATO)) dut (
      .clk12_i                   (clk),
      .rst_i                     (rst_i),
      .gotTransStartPacket_i     (got_tok),
      .transStartTokenID_i       (tok_id),
      .rxDataValid_i             (rx_valid),
      .rxData_i                  (rx_data),
      .rxPacketDone_i            (rx_done),
      .rxPacketOk_i              (rx_ok),
      .rxDataToggle_i            (rx_tgl),
      .hostAck_i                 (host_ack),
      .respAck_i                 (resp_ack),
      .txPopData_i               (tx_pop),
      .txDone_i                  (tx_done),
`ifdef USB_EP_HALT_EN
      .halt_i                    (halt),
`endif
      .EP_OUT_dataValid_o        (out_valid),
      .EP_OUT_data_o             (out_data),
      .EP_OUT_fillTransDone_o    (out_fill_done),
      .EP_OUT_fillTransSuccess_o (out_fill_succ),
      .EP_OUT_full_i             (out_full),
      .EP_IN_popData_o           (in_pop),
      .EP_IN_popTransDone_o      (in_pop_done),
      .EP_IN_popTransSuccess_o   (in_pop_succ),
      .EP_IN_dataAvailable_i     (in_avail),
      .EP_IN_data_i              (in_data),
      .txDataAvailable_o         (tx_avail),
      .txData_o                  (tx_data),
      .respValid_o               (resp_valid),
      .respHandshakePID_o        (resp_hs),
      .respPacketID_o            (resp_pid),
      .busy_o                    (busy)
   );

   // ---------------- IN FIFO environment model (commit/rewind) ----------------
   logic [7:0] fifo_mem [0:255];
   int wr_p = 0, rd_p = 0, cm_p = 0;
   assign in_avail = (rd_p != wr_p);
   assign in_data  = fifo_mem[rd_p[7:0]];

   always @(posedge clk) begin
      if (in_pop) rd_p <= rd_p + 1;
      if (in_pop_done) begin
         if (in_pop_succ) cm_p <= rd_p;
         else             rd_p <= cm_p;
      end
   end

   // ---------------- scoreboard ----------------
   typedef enum logic [2:0] {EV_WR, EV_FILL, EV_RESP, EV_POP, EV_POPDONE} ev_e;
   typedef struct {
      ev_e        kind;
      logic [7:0] val;
   } ev_t;
   ev_t exp_q[$];

   int checks = 0, failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void push(input ev_e k, input logic [7:0] v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endfunction

   task automatic sb_check(input ev_e k, input logic [7:0] v);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_unexpected: got %s val=%02h expected nothing", k.name(), v);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== k || e.val !== v) begin
            failures++;
            $display("FAIL scoreboard: got %s val=%02h expected %s val=%02h",
                     k.name(), v, e.kind.name(), e.val);
         end
      end
   endtask

   logic prev_resp = 1'b0;
   always @(negedge clk) begin
      if (!rst_i) begin
         if (out_valid)                sb_check(EV_WR, out_data);
         if (out_fill_done)            sb_check(EV_FILL, {7'b0, out_fill_succ});
         if (resp_valid && !prev_resp) sb_check(EV_RESP, {5'b0, resp_hs, resp_pid});
         if (in_pop)                   sb_check(EV_POP, tx_data);
         if (in_pop_done)              sb_check(EV_POPDONE, {7'b0, in_pop_succ});
      end
      prev_resp <= resp_valid;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_token(input logic [1:0] t);
      got_tok = 1'b1;
      tok_id  = t;
      tick();
      got_tok = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 50; k++) begin
         if (!busy) break;
         tick();
      end
      check(name, busy, 1'b0);
   endtask

   task automatic resp_handshake();
      int k;
      for (k = 0; k < 20; k++) begin
         if (resp_valid) break;
         tick();
      end
      if (!resp_valid) begin
         checks++;
         failures++;
         $display("FAIL resp_wait: got no respValid expected respValid within 20 cycles");
      end
      resp_ack = 1'b1;
      tick();
      resp_ack = 1'b0;
   endtask

   function automatic void fifo_load(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         fifo_mem[wr_p] = base + 8'(i);
         wr_p++;
      end
   endfunction

   // OUT/SETUP transaction: n payload bytes, expected writes/commit/response queued up front
   task automatic out_pkt(input logic [1:0] t, input int n, input logic [7:0] base,
                          input logic tgl, input logic ok, input int exp_wr,
                          input logic exp_succ, input logic has_resp, input logic [1:0] exp_pid);
      for (int i = 0; i < exp_wr; i++) push(EV_WR, base + 8'(i));
      push(EV_FILL, {7'b0, exp_succ});
      if (has_resp) push(EV_RESP, {5'b0, 1'b1, exp_pid});
      send_token(t);
      for (int i = 0; i < n; i++) begin
         rx_valid = 1'b1;
         rx_data  = base + 8'(i);
         tick();
      end
      rx_valid = 1'b0;
      rx_done  = 1'b1;
      rx_ok    = ok;
      rx_tgl   = tgl;
      tick();
      rx_done  = 1'b0;
      if (has_resp) resp_handshake();
      wait_idle("out_idle");
   endtask

   // IN transaction. mode: 0 host ACK, 1 ACK timeout, 2 aborted by a new token
   task automatic in_trans(input int n_pop, input logic [7:0] base, input logic hs,
                           input logic [1:0] pid, input int mode, input int pop_cycles);
      int cnt;
      push(EV_RESP, {5'b0, hs, pid});
      if (!hs) begin
         for (int i = 0; i < n_pop; i++) push(EV_POP, base + 8'(i));
         push(EV_POPDONE, {7'b0, (mode == 0)});
      end
      send_token(TOK_IN);
      resp_handshake();
      if (!hs) begin
         tx_pop = 1'b1;
         repeat (pop_cycles) tick();
         tx_pop  = 1'b0;
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         if (mode == 0) begin
            host_ack = 1'b1;
            tick();
            host_ack = 1'b0;
         end else if (mode == 1) begin
            cnt = 0;
            while (cnt < ATO + 10) begin
               @(posedge clk);
               cnt++;
               @(negedge clk);
               if (in_pop_done) break;
            end
            check("ack_timeout_latency", cnt, ATO);
            tick();
         end else begin
            send_token(TOK_OUT);
         end
      end
      wait_idle("in_idle");
   endtask

   // Hard stop in case something unforeseen blocks the sequence
   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected summary before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      rst_i = 1'b0;
      tick();
      check("reset_outputs",
            {out_valid, out_data, out_fill_done, out_fill_succ, in_pop, in_pop_done,
             in_pop_succ, tx_avail, tx_data, resp_valid, resp_hs, resp_pid, busy}, '0);

      // OUT 8 bytes DATA0 with outToggle=0 -> commit, ACK; outToggle=1
      out_pkt(TOK_OUT, 8, 8'h10, 1'b0, 1'b1, 8, 1'b1, 1'b1, PID_ACK);
      // DATA0 again while outToggle=1 -> ACKed but discarded
      out_pkt(TOK_OUT, 3, 8'h20, 1'b0, 1'b1, 3, 1'b0, 1'b1, PID_ACK);
      // DATA1 accepted, proving outToggle stayed 1; outToggle=0
      out_pkt(TOK_OUT, 2, 8'h30, 1'b1, 1'b1, 2, 1'b1, 1'b1, PID_ACK);
      // 70 bytes: only 64 written, overflow -> NAK
      out_pkt(TOK_OUT, 70, 8'h40, 1'b0, 1'b1, 64, 1'b0, 1'b1, PID_NAK);
      // Bad CRC: rewind, no response
      out_pkt(TOK_OUT, 2, 8'h90, 1'b0, 1'b0, 2, 1'b0, 1'b0, PID_ACK);
      // Zero-length DATA0 (outToggle still 0) -> commit 0 bytes; outToggle=1
      out_pkt(TOK_OUT, 0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b1, PID_ACK);

      // IN with empty FIFO -> NAK
      in_trans(0, 8'h00, 1'b1, PID_NAK, 0, 0);
      // IN 5 bytes, DATA0, host ACK; inToggle=1
      fifo_load(5, 8'hA0);
      in_trans(5, 8'hA0, 1'b0, PID_DATA0, 0, 8);
      // IN 3 bytes DATA1, ACK lost -> rewind; retry resends the same bytes
      fifo_load(3, 8'hB0);
      in_trans(3, 8'hB0, 1'b0, PID_DATA1, 1, 5);
      in_trans(3, 8'hB0, 1'b0, PID_DATA1, 0, 5);
      // IN with 70 bytes queued: exactly 64 pops, then the remaining 6
      fifo_load(70, 8'h40);
      in_trans(64, 8'h40, 1'b0, PID_DATA0, 0, 70);
      in_trans(6, 8'h80, 1'b0, PID_DATA1, 0, 8);

      // SETUP DATA0 while outToggle=1 -> accepted; both toggles become 1
      out_pkt(TOK_SETUP, 8, 8'hC0, 1'b0, 1'b1, 8, 1'b1, 1'b1, PID_ACK);
      fifo_load(1, 8'hD0);
      in_trans(1, 8'hD0, 1'b0, PID_DATA1, 0, 3);
      out_pkt(TOK_OUT, 1, 8'hD8, 1'b1, 1'b1, 1, 1'b1, 1'b1, PID_ACK);

      // SOF is ignored
      send_token(TOK_SOF);
      check("sof_ignored", busy, 1'b0);

      // New token while waiting for ACK -> rewind, token dropped, retry succeeds
      fifo_load(2, 8'hE0);
      in_trans(2, 8'hE0, 1'b0, PID_DATA0, 2, 4);
      in_trans(2, 8'hE0, 1'b0, PID_DATA0, 0, 4);

`ifdef USB_EP_HALT_EN
      // Halted endpoint: STALL for IN and OUT, no pops and no writes
      fifo_load(1, 8'hF0);
      halt = 1'b1;
      in_trans(0, 8'h00, 1'b1, PID_STALL, 0, 0);
      out_pkt(TOK_OUT, 2, 8'hF8, 1'b0, 1'b1, 0, 1'b0, 1'b1, PID_STALL);
      halt = 1'b0;
      in_trans(1, 8'hF0, 1'b0, PID_DATA1, 0, 3);
`endif

      repeat (3) tick();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
